// File: rtl/pad_bank_pkg.sv
// Shared register map, CFG field layout and reset value for the pad bank controller.
// PAD_GLITCH_FILTER_EN decides whether FILT_EN is a writable CFG bit.
package pad_bank_pkg;

   localparam int unsigned AddrW = 6;
   localparam int unsigned DataW = 32;
   localparam int unsigned CfgW  = 11;

   localparam logic [AddrW-1:0] CfgBase  = 6'd0;
   localparam logic [AddrW-1:0] RiseAddr = 6'd32;
   localparam logic [AddrW-1:0] FallAddr = 6'd33;
   localparam logic [AddrW-1:0] InAddr   = 6'd34;
   localparam logic [AddrW-1:0] MaskAddr = 6'd35;

   localparam int unsigned OeSwBit     = 0;
   localparam int unsigned IeBit       = 1;
   localparam int unsigned DsLsb       = 2;
   localparam int unsigned PeBit       = 4;
   localparam int unsigned PsBit       = 5;
   localparam int unsigned IsBit       = 6;
   localparam int unsigned SrBit       = 7;
   localparam int unsigned FiltEnBit   = 8;
   localparam int unsigned CoreCtrlBit = 9;
   localparam int unsigned OutSwBit    = 10;

   typedef struct packed {
      logic       out_sw;
      logic       core_ctrl;
      logic       filt_en;
      logic       sr;
      logic       schmitt;
      logic       ps;
      logic       pe;
      logic [1:0] ds;
      logic       ie;
      logic       oe_sw;
   } pad_cfg_t;

   // Tristated, input disabled, pull-down enabled.
   localparam pad_cfg_t PadCfgRst = pad_cfg_t'(11'h010);

   // Converts the writable CFG bits of a bus word into a CFG value.
   function automatic pad_cfg_t cfg_from_word(input logic [CfgW-1:0] w);
      logic [CfgW-1:0] bits;
      bits = w;
`ifndef PAD_GLITCH_FILTER_EN
      bits[FiltEnBit] = 1'b0;
`endif
      return pad_cfg_t'(bits);
   endfunction

endpackage

// File: rtl/pad_bank_ctrl_in_cond.sv
// Per-pad input conditioning: IE-gated synchroniser, optional glitch filter
// (PAD_GLITCH_FILTER_EN) and rise/fall pulses of the conditioned value.
module pad_in_cond
   import pad_bank_pkg::*;
#(
   parameter int unsigned SyncStages   = 2,
   parameter int unsigned FilterCycles = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_y,
   input  logic ie,
   input  logic filt_en,
   output logic y,
   output logic rise_c,
   output logic fall_c
);

   logic [SyncStages-1:0] sync_q;
   logic                  sync;
   logic                  filt_q;
   logic                  prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], pad_y & ie};
      end
   end

   assign sync = sync_q[SyncStages-1];

`ifdef PAD_GLITCH_FILTER_EN
   localparam int unsigned CntW = 8;
   logic [CntW-1:0] cnt_q;

   // Filtered value only moves after FilterCycles consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (!filt_en) begin
         cnt_q  <= '0;
         filt_q <= sync;
      end else if (sync == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q + CntW'(1) == CntW'(FilterCycles)) begin
         cnt_q  <= '0;
         filt_q <= sync;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end
`else
   localparam int unsigned unused_filter_cycles = FilterCycles;
   logic unused_filt_en;
   assign unused_filt_en = filt_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
      end else begin
         filt_q <= sync;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= filt_q;
      end
   end

   assign y      = filt_q;
   assign rise_c = filt_q & ~prev_q;
   assign fall_c = ~filt_q & prev_q;

endmodule

// File: rtl/pad_bank_ctrl.sv
// Register-configured controller for a bank of bidirectional pads with
// conditioned inputs and edge interrupts; PAD_GLITCH_FILTER_EN enables the glitch filter.
module pad_bank_ctrl
   import pad_bank_pkg::*;
#(
   parameter int unsigned NumPads      = 16,
   parameter int unsigned SyncStages   = 2,
   parameter int unsigned FilterCycles = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [AddrW-1:0]   addr_i,
   input  logic [DataW-1:0]   wdata_i,
   output logic               gnt_o,
   output logic               rvalid_o,
   output logic [DataW-1:0]   rdata_o,
   output logic               err_o,
   input  logic [NumPads-1:0] core_a_i,
   input  logic [NumPads-1:0] core_oe_i,
   output logic [NumPads-1:0] core_y_o,
   output logic [NumPads-1:0] pad_a_o,
   output logic [NumPads-1:0] pad_oe_o,
   output logic [NumPads-1:0] pad_ie_o,
   output logic [NumPads-1:0] pad_ds0_o,
   output logic [NumPads-1:0] pad_ds1_o,
   output logic [NumPads-1:0] pad_pe_o,
   output logic [NumPads-1:0] pad_ps_o,
   output logic [NumPads-1:0] pad_is_o,
   output logic [NumPads-1:0] pad_sr_o,
   input  logic [NumPads-1:0] pad_y_i,
   output logic               irq_o
);

   pad_cfg_t           cfg_q [NumPads];
   logic [NumPads-1:0] rise_q, fall_q, mask_q;
   logic [NumPads-1:0] rise_c, fall_c, rise_clr_c, fall_clr_c;
   logic               rvalid_q, err_q, irq_q;
   logic [DataW-1:0]   rdata_q;
   logic               wr_c, cfg_hit_c, dec_err_c;
   logic [DataW-1:0]   rd_word_c;
   logic               unused_wdata;

   assign unused_wdata = ^wdata_i;
   assign gnt_o        = req_i;
   assign wr_c         = req_i & we_i;
   assign cfg_hit_c    = 32'(addr_i) < 32'(CfgBase) + NumPads;
   assign dec_err_c    = !(cfg_hit_c || addr_i == RiseAddr || addr_i == FallAddr ||
                           addr_i == InAddr || addr_i == MaskAddr);
   assign rise_clr_c   = (wr_c && addr_i == RiseAddr) ? wdata_i[NumPads-1:0] : '0;
   assign fall_clr_c   = (wr_c && addr_i == FallAddr) ? wdata_i[NumPads-1:0] : '0;

   // Read mux; undecoded addresses return 0.
   always_comb begin
      rd_word_c = '0;
      for (int p = 0; p < int'(NumPads); p++) begin
         if (addr_i == CfgBase + AddrW'(p)) begin
            rd_word_c = {{(DataW-CfgW){1'b0}}, cfg_q[p]};
         end
      end
      case (addr_i)
         RiseAddr: rd_word_c = DataW'(rise_q);
         FallAddr: rd_word_c = DataW'(fall_q);
         InAddr:   rd_word_c = DataW'(core_y_o);
         MaskAddr: rd_word_c = DataW'(mask_q);
         default:  ;
      endcase
   end

   // Configuration, sticky status (edge set beats same-cycle clear) and interrupt.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < int'(NumPads); p++) begin
            cfg_q[p] <= PadCfgRst;
         end
         rise_q <= '0;
         fall_q <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (wr_c) begin
            for (int p = 0; p < int'(NumPads); p++) begin
               if (addr_i == CfgBase + AddrW'(p)) begin
                  cfg_q[p] <= cfg_from_word(wdata_i[CfgW-1:0]);
               end
            end
            if (addr_i == MaskAddr) begin
               mask_q <= wdata_i[NumPads-1:0];
            end
         end
         rise_q <= (rise_q & ~rise_clr_c) | rise_c;
         fall_q <= (fall_q & ~fall_clr_c) | fall_c;
         irq_q  <= |((rise_q | fall_q) & mask_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= req_i;
         err_q    <= req_i & dec_err_c;
         rdata_q  <= (req_i && !we_i && !dec_err_c) ? rd_word_c : '0;
      end
   end

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;
   assign irq_o    = irq_q;

   for (genvar g = 0; g < int'(NumPads); g++) begin : g_pad
      logic [CfgW-1:0] cb;
      assign cb           = cfg_q[g];
      assign pad_oe_o[g]  = cb[CoreCtrlBit] ? core_oe_i[g] : cb[OeSwBit];
      assign pad_a_o[g]   = cb[CoreCtrlBit] ? core_a_i[g]  : cb[OutSwBit];
      assign pad_ie_o[g]  = cb[IeBit];
      assign pad_ds0_o[g] = cb[DsLsb];
      assign pad_ds1_o[g] = cb[DsLsb+1];
      assign pad_pe_o[g]  = cb[PeBit];
      assign pad_ps_o[g]  = cb[PsBit];
      assign pad_is_o[g]  = cb[IsBit];
      assign pad_sr_o[g]  = cb[SrBit];

      pad_in_cond #(
         .SyncStages   (SyncStages),
         .FilterCycles (FilterCycles)
      ) u_in_cond (
         .clk     (clk_i),
         .rst     (rst_i),
         .pad_y   (pad_y_i[g]),
         .ie      (cb[IeBit]),
         .filt_en (cb[FiltEnBit]),
         .y       (core_y_o[g]),
         .rise_c  (rise_c[g]),
         .fall_c  (fall_c[g])
      );
   end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Self-checking bench for pad_bank_ctrl; bus responses are scored from a queue of expected values.
module tb_pad_bank_ctrl;

   localparam int unsigned NumPads      = 16;
   localparam int unsigned SyncStages   = 2;
   localparam int unsigned FilterCycles = 4;
`ifdef PAD_GLITCH_FILTER_EN
   localparam int unsigned Lat     = SyncStages + FilterCycles;
   localparam logic [31:0] CfgMask = 32'h0000_07FF;
`else
   localparam int unsigned Lat     = SyncStages + 1;
   localparam logic [31:0] CfgMask = 32'h0000_06FF;
`endif

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic               req_i = 1'b0;
   logic               we_i = 1'b0;
   logic [5:0]         addr_i = '0;
   logic [31:0]        wdata_i = '0;
   logic               gnt_o, rvalid_o, err_o, irq_o;
   logic [31:0]        rdata_o;
   logic [NumPads-1:0] core_a_i = '0;
   logic [NumPads-1:0] core_oe_i = '0;
   logic [NumPads-1:0] pad_y_i = '0;
   logic [NumPads-1:0] core_y_o, pad_a_o, pad_oe_o, pad_ie_o, pad_ds0_o, pad_ds1_o;
   logic [NumPads-1:0] pad_pe_o, pad_ps_o, pad_is_o, pad_sr_o;

   exp_t        exp_q[$];
   logic [31:0] cfg_model [NumPads];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk_i = ~clk_i;

   pad_bank_ctrl #(
      .NumPads      (NumPads),
      .SyncStages   (SyncStages),
      .FilterCycles (FilterCycles)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .gnt_o     (gnt_o),
      .rvalid_o  (rvalid_o),
      .rdata_o   (rdata_o),
      .err_o     (err_o),
      .core_a_i  (core_a_i),
      .core_oe_i (core_oe_i),
      .core_y_o  (core_y_o),
      .pad_a_o   (pad_a_o),
      .pad_oe_o  (pad_oe_o),
      .pad_ie_o  (pad_ie_o),
      .pad_ds0_o (pad_ds0_o),
      .pad_ds1_o (pad_ds1_o),
      .pad_pe_o  (pad_pe_o),
      .pad_ps_o  (pad_ps_o),
      .pad_is_o  (pad_is_o),
      .pad_sr_o  (pad_sr_o),
      .pad_y_i   (pad_y_i),
      .irq_o     (irq_o)
   );

   // Advance one clock; score the response owed for the request sampled at this edge.
   task automatic tick();
      exp_t e;
      @(posedge clk_i);
      #1;
      n_checks++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rvalid_o !== 1'b1 || rdata_o !== e.rdata || err_o !== e.err) begin
            n_fail++;
            $display("FAIL response: rvalid=%b rdata=%h err=%b, expected rvalid=1 rdata=%h err=%b",
                     rvalid_o, rdata_o, err_o, e.rdata, e.err);
         end
      end else if (rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_rvalid: rvalid=%b, expected 0", rvalid_o);
      end
   endtask

   // One-cycle bus request; the expected response goes on the scoreboard.
   task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
      exp_q.push_back('{rdata: er, err: ee});
      #1;
      n_checks++;
      if (gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL gnt: gnt=%b, expected 1", gnt_o);
      end
      tick();
      req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      n_checks++;
      if (pad_oe_o !== 16'h0000 || pad_ie_o !== 16'h0000 || pad_pe_o !== 16'hFFFF || irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: oe=%h ie=%h pe=%h irq=%b, expected 0000 0000 ffff 0",
                  pad_oe_o, pad_ie_o, pad_pe_o, irq_o);
      end
      bus(1'b0, 6'd0, 32'h0, 32'h10, 1'b0);
   endtask

   task automatic test_sw_drive();
      bus(1'b1, 6'd3, 32'h401, 32'h0, 1'b0);
      n_checks++;
      if (pad_oe_o !== 16'h0008 || pad_a_o[3] !== 1'b1 || pad_pe_o[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_drive: oe=%h a3=%b pe3=%b, expected 0008 1 0", pad_oe_o, pad_a_o[3], pad_pe_o[3]);
      end
      bus(1'b0, 6'd3, 32'h0, 32'h401, 1'b0);
      bus(1'b1, 6'd3, 32'h200, 32'h0, 1'b0);
      core_oe_i = 16'h0008; core_a_i = 16'h0000;
      #1;
      n_checks++;
      if (pad_oe_o[3] !== 1'b1 || pad_a_o[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL core_ctrl_a: oe3=%b a3=%b, expected 1 0", pad_oe_o[3], pad_a_o[3]);
      end
      core_oe_i = 16'h0000; core_a_i = 16'h0008;
      #1;
      n_checks++;
      if (pad_oe_o[3] !== 1'b0 || pad_a_o[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL core_ctrl_b: oe3=%b a3=%b, expected 0 1", pad_oe_o[3], pad_a_o[3]);
      end
      core_a_i = 16'h0000;
      bus(1'b1, 6'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
      n_checks++;
      if ({pad_ds1_o[1], pad_ds0_o[1], pad_ps_o[1], pad_is_o[1], pad_sr_o[1], pad_ie_o[1]} !== 6'b111111 ||
          pad_pe_o !== 16'hFFF7 || pad_oe_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL cfg_fields: ds1/ds0/ps/is/sr/ie=%b pe=%h oe=%h, expected 111111 fff7 0000",
                  {pad_ds1_o[1], pad_ds0_o[1], pad_ps_o[1], pad_is_o[1], pad_sr_o[1], pad_ie_o[1]},
                  pad_pe_o, pad_oe_o);
      end
      bus(1'b0, 6'd1, 32'h0, CfgMask, 1'b0);
      bus(1'b1, 6'd1, 32'h10, 32'h0, 1'b0);
   endtask

   task automatic test_glitch_filter();
      logic exp_y;
      bus(1'b1, 6'd5, 32'h102, 32'h0, 1'b0);
      bus(1'b0, 6'd5, 32'h0, 32'h102 & CfgMask, 1'b0);
      for (int i = 0; i < 13; i++) begin
         pad_y_i[5] = (i < 3);
         tick();
`ifdef PAD_GLITCH_FILTER_EN
         n_checks++;
         if (core_y_o[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_suppress: cycle %0d core_y5=%b, expected 0", i, core_y_o[5]);
         end
`endif
      end
`ifdef PAD_GLITCH_FILTER_EN
      bus(1'b0, 6'd32, 32'h0, 32'h0, 1'b0);
      bus(1'b0, 6'd33, 32'h0, 32'h0, 1'b0);
`else
      bus(1'b0, 6'd32, 32'h0, 32'h20, 1'b0);
      bus(1'b0, 6'd33, 32'h0, 32'h20, 1'b0);
      bus(1'b1, 6'd32, 32'h20, 32'h0, 1'b0);
      bus(1'b1, 6'd33, 32'h20, 32'h0, 1'b0);
      bus(1'b0, 6'd32, 32'h0, 32'h0, 1'b0);
`endif
      pad_y_i[5] = 1'b1;
      for (int k = 1; k <= int'(Lat); k++) begin
         tick();
         exp_y = (k >= int'(Lat));
         n_checks++;
         if (core_y_o[5] !== exp_y) begin
            n_fail++;
            $display("FAIL input_latency: cycle %0d core_y5=%b, expected %b", k, core_y_o[5], exp_y);
         end
      end
      bus(1'b0, 6'd32, 32'h0, 32'h0, 1'b0);
      bus(1'b0, 6'd32, 32'h0, 32'h20, 1'b0);
      bus(1'b0, 6'd34, 32'h0, 32'h20, 1'b0);
   endtask

   task automatic test_irq_clear();
      bus(1'b1, 6'd35, 32'h20, 32'h0, 1'b0);
      n_checks++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_delay: irq=%b, expected 0", irq_o);
      end
      tick();
      n_checks++;
      if (irq_o !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_rise: irq=%b, expected 1", irq_o);
      end
      bus(1'b1, 6'd32, 32'h20, 32'h0, 1'b0);
      bus(1'b0, 6'd32, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_cleared: irq=%b, expected 0", irq_o);
      end
      pad_y_i[5] = 1'b0;
      repeat (Lat + 2) tick();
      n_checks++;
      if (irq_o !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_fall: irq=%b, expected 1", irq_o);
      end
      bus(1'b0, 6'd33, 32'h0, 32'h20, 1'b0);
      bus(1'b1, 6'd33, 32'h20, 32'h0, 1'b0);
      tick();
      n_checks++;
      if (irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_fall_cleared: irq=%b, expected 0", irq_o);
      end
      pad_y_i[5] = 1'b1;
      repeat (Lat) tick();
      bus(1'b1, 6'd32, 32'h20, 32'h0, 1'b0);
      bus(1'b0, 6'd32, 32'h0, 32'h20, 1'b0);
      n_checks++;
      if (irq_o !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_clear_irq: irq=%b, expected 1", irq_o);
      end
   endtask

   task automatic test_decode();
      bus(1'b0, 6'd20, 32'h0, 32'h0, 1'b1);
      bus(1'b1, 6'd40, 32'hFFFF_FFFF, 32'h0, 1'b1);
      bus(1'b0, 6'd36, 32'h0, 32'h0, 1'b1);
      bus(1'b1, 6'd16, 32'hFFFF_FFFF, 32'h0, 1'b1);
      bus(1'b1, 6'd34, 32'hFFFF_FFFF, 32'h0, 1'b0);
      bus(1'b0, 6'd34, 32'h0, 32'h20, 1'b0);
      bus(1'b0, 6'd35, 32'h0, 32'h20, 1'b0);
      bus(1'b0, 6'd3, 32'h0, 32'h200, 1'b0);
      bus(1'b0, 6'd0, 32'h0, 32'h10, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0]        d;
      logic [NumPads-1:0] e_ie, e_pe, e_ds1, e_sr, e_oe, e_a;
      core_oe_i = NumPads'($urandom);
      core_a_i  = NumPads'($urandom);
      for (int p = 0; p < int'(NumPads); p++) begin
         d = $urandom;
         cfg_model[p] = d & CfgMask;
         bus(1'b1, 6'(p), d, 32'h0, 1'b0);
      end
      for (int p = 0; p < int'(NumPads); p++) begin
         d = cfg_model[p];
         e_ie[p]  = d[1];
         e_ds1[p] = d[3];
         e_pe[p]  = d[4];
         e_sr[p]  = d[7];
         e_oe[p]  = d[9] ? core_oe_i[p] : d[0];
         e_a[p]   = d[9] ? core_a_i[p] : d[10];
      end
      n_checks++;
      if (pad_ie_o !== e_ie || pad_pe_o !== e_pe || pad_ds1_o !== e_ds1 || pad_sr_o !== e_sr ||
          pad_oe_o !== e_oe || pad_a_o !== e_a) begin
         n_fail++;
         $display("FAIL b2b_pads: ie=%h pe=%h ds1=%h sr=%h oe=%h a=%h, expected %h %h %h %h %h %h",
                  pad_ie_o, pad_pe_o, pad_ds1_o, pad_sr_o, pad_oe_o, pad_a_o,
                  e_ie, e_pe, e_ds1, e_sr, e_oe, e_a);
      end
      for (int p = 0; p < int'(NumPads); p++) begin
         bus(1'b0, 6'(p), 32'h0, cfg_model[p], 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      bus(1'b0, 6'd3, 32'h0, cfg_model[3], 1'b0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      n_checks++;
      if (pad_oe_o !== 16'h0000 || pad_a_o !== 16'h0000 || pad_ie_o !== 16'h0000 ||
          pad_pe_o !== 16'hFFFF || irq_o !== 1'b0 || core_y_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_mid: oe=%h a=%h ie=%h pe=%h irq=%b y=%h, expected 0000 0000 0000 ffff 0 0000",
                  pad_oe_o, pad_a_o, pad_ie_o, pad_pe_o, irq_o, core_y_o);
      end
      for (int p = 0; p < int'(NumPads); p++) begin
         bus(1'b0, 6'(p), 32'h0, 32'h10, 1'b0);
      end
      bus(1'b0, 6'd35, 32'h0, 32'h0, 1'b0);
      bus(1'b0, 6'd32, 32'h0, 32'h0, 1'b0);
      bus(1'b0, 6'd33, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_sw_drive();
      test_glitch_filter();
      test_irq_clear();
      test_decode();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
